// File: rtl/rxshift_if.sv
// rxshift_if: enable/baud/serial inputs and received-byte outputs shared between the
// register side (master) and the rxshift receiver (slave).
interface rxshift_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BAUD_W = 8;

    logic              i_Enable;
    logic [BAUD_W-1:0] i_Baud;
    logic              i_Rx_Serial;
    logic [DATA_W-1:0] o_Data;
    logic              o_Valid;
    logic              o_Frame_Err;
    logic              o_Parity_Err;
    logic              o_Busy;

    modport master (
        output i_Enable, i_Baud, i_Rx_Serial,
        input  o_Data, o_Valid, o_Frame_Err, o_Parity_Err, o_Busy
    );

    modport slave (
        input  i_Enable, i_Baud, i_Rx_Serial,
        output o_Data, o_Valid, o_Frame_Err, o_Parity_Err, o_Busy
    );
endinterface

// File: rtl/rxshift.sv
// rxshift: serial receiver; start detect, centre sampling at i_Baud clocks per bit, 8 data bits
// LSB first, stop check. Define RXSHIFT_PARITY_EN to add an even-parity bit before the stop bit.
module rxshift #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic     i_Pclk,
    input  logic     i_Reset,
    rxshift_if.slave bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned XW = CW + 1;
    localparam int unsigned IW = 3;
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] S_IDLE   = 3'd0;
    localparam logic [SW-1:0] S_START  = 3'd1;
    localparam logic [SW-1:0] S_DATA   = 3'd2;
    localparam logic [SW-1:0] S_STOP   = 3'd3;
    localparam logic [SW-1:0] S_BREAK  = 3'd4;
`ifdef RXSHIFT_PARITY_EN
    localparam logic [SW-1:0] S_PARITY = 3'd5;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [SW-1:0] state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] baud_q,  baud_d;
    logic [DW-1:0] data_q,  data_d;
    logic          valid_q, valid_d;
    logic          ferr_q,  ferr_d;
    logic          busy_q,  busy_d;
`ifdef RXSHIFT_PARITY_EN
    logic          par_q,   par_d;
    logic          perr_q,  perr_d;
`endif

    logic [CW-1:0] baud_in_c;
    logic [CW-1:0] half_c;
    logic          bit_end_c;

    // Metastability synchroniser; resets to the idle (high) line level
    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_Rx_Serial};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Baud values 0 and 1 both mean one clock per bit
    assign baud_in_c = (bus.i_Baud < CW'(2)) ? CW'(1) : bus.i_Baud;
    assign half_c    = CW'((baud_q - CW'(1)) >> 1);
    // Widened compare keeps B-1 well defined at B=1
    assign bit_end_c = ({1'b0, cnt_q} == (XW'(baud_q) - XW'(1)));

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            baud_q  <= CW'(1);
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RXSHIFT_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef RXSHIFT_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        baud_d  = baud_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef RXSHIFT_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif

        if (!bus.i_Enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        cnt_d   = '0;
                        baud_d  = baud_in_c;
                    end
                end

                S_START: begin
                    if (cnt_q < half_c) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (rx_s) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end

                S_DATA: begin
                    if (bit_end_c) begin
                        shreg_d[idx_q] = rx_s;
                        cnt_d          = '0;
                        idx_d          = idx_q + IW'(1);
                        if (idx_q == IW'(DW - 1)) begin
`ifdef RXSHIFT_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

`ifdef RXSHIFT_PARITY_EN
                S_PARITY: begin
                    if (bit_end_c) begin
                        par_d   = rx_s;
                        cnt_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end_c) begin
                        cnt_d = '0;
`ifdef RXSHIFT_PARITY_EN
                        perr_d = par_q ^ (^shreg_q);
`endif
                        if (rx_s) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                // Held-low line must return high before a new start is accepted
                S_BREAK: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.o_Data      = data_q;
    assign bus.o_Valid     = valid_q;
    assign bus.o_Frame_Err = ferr_q;
    assign bus.o_Busy      = busy_q;
`ifdef RXSHIFT_PARITY_EN
    assign bus.o_Parity_Err = perr_q;
`else
    assign bus.o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_rxshift.sv
// tb_rxshift: directed self-checking bench for rxshift (frames driven bit by bit from the bench).
module tb_rxshift;
`ifdef RXSHIFT_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    rxshift_if bus ();

    rxshift #(.SYNC_STAGES(2)) dut (
        .i_Pclk  (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int long_pulse = 0;
    int valid_cyc = 0;
    int busy_rise_cyc = 0;
    int busy_run = 0;
    int busy_len = 0;
    logic perr_at_valid = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;
    logic prev_perr = 1'b0;
    logic prev_busy = 1'b0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: pulses, their widths, busy edges and received bytes
    always @(negedge clk) begin
        if (bus.o_Valid === 1'b1) begin
            got_q.push_back(bus.o_Data);
            valid_cnt++;
            valid_cyc = cyc;
            perr_at_valid = bus.o_Parity_Err;
            if (prev_valid) long_pulse++;
        end
        if (bus.o_Frame_Err === 1'b1) begin
            ferr_cnt++;
            if (prev_ferr) long_pulse++;
        end
        if (bus.o_Parity_Err === 1'b1) begin
            perr_cnt++;
            if (prev_perr) long_pulse++;
        end
        if (bus.o_Busy === 1'b1) begin
            if (!prev_busy) busy_rise_cyc = cyc;
            busy_run++;
        end else if (prev_busy) begin
            busy_len = busy_run;
            busy_run = 0;
        end
        prev_valid = (bus.o_Valid === 1'b1);
        prev_ferr  = (bus.o_Frame_Err === 1'b1);
        prev_perr  = (bus.o_Parity_Err === 1'b1);
        prev_busy  = (bus.o_Busy === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        bus.i_Rx_Serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int b);
        bus.i_Rx_Serial = v;
        repeat (b) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int b, input logic stop_v, input int stop_bits);
        drive_bit(1'b0, b);
        for (int i = 0; i < 8; i++) drive_bit(d[i], b);
`ifdef RXSHIFT_PARITY_EN
        drive_bit(^d, b);
`endif
        drive_bit(stop_v, b * stop_bits);
        bus.i_Rx_Serial = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (bus.o_Data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want %h", bus.o_Data, 8'h00); end
        checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.o_Valid); end
        checks++; if (bus.o_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus.o_Frame_Err); end
        checks++; if (bus.o_Parity_Err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", bus.o_Parity_Err); end
        checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_Busy); end
        @(negedge clk);
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_clean();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        bus.i_Baud = 8'd4;
        send_frame(8'hA5, 4, 1'b1, 1);
        idle(12);
        checks++; if (bus.o_Data !== 8'hA5) begin errors++; $display("FAIL clean_data got %h want %h", bus.o_Data, 8'hA5); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL clean_valid_count got %0d want 1", valid_cnt - v0); end
        checks++; if (long_pulse !== 0) begin errors++; $display("FAIL clean_pulse_width got %0d long pulses want 0", long_pulse); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL clean_ferr got %0d want 0", ferr_cnt - f0); end
        checks++; if (valid_cyc - busy_rise_cyc !== 2 + NBITS * 4) begin errors++; $display("FAIL clean_latency got %0d want %0d", valid_cyc - busy_rise_cyc, 2 + NBITS * 4); end
        checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL clean_busy_after got %b want 0", bus.o_Busy); end
    endtask

    task automatic test_back_to_back();
        int v0, f0, p0;
        logic [7:0] exp [3];
        logic [7:0] got;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        got_q.delete();
        bus.i_Baud = 8'd8;
        for (int i = 0; i < 3; i++) send_frame(exp[i], 8, 1'b1, 1);
        idle(20);
        checks++; if (valid_cnt - v0 !== 3) begin errors++; $display("FAIL b2b_valid_count got %0d want 3", valid_cnt - v0); end
        for (int i = 0; i < 3; i++) begin
            got = (got_q.size() > i) ? got_q[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, got, exp[i]); end
        end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr got %0d want 0", ferr_cnt - f0); end
        checks++; if (perr_cnt - p0 !== 0) begin errors++; $display("FAIL b2b_perr got %0d want 0", perr_cnt - p0); end
        checks++; if (long_pulse !== 0) begin errors++; $display("FAIL b2b_pulse_width got %0d long pulses want 0", long_pulse); end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        bus.i_Baud = 8'd4;
        send_frame(8'h55, 4, 1'b0, 3);
        checks++; if (bus.o_Busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break got %b want 1", bus.o_Busy); end
        idle(40);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_cnt - f0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", valid_cnt - v0); end
        checks++; if (bus.o_Data !== 8'h3C) begin errors++; $display("FAIL ferr_data_held got %h want %h", bus.o_Data, 8'h3C); end
        checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_after got %b want 0", bus.o_Busy); end
        checks++; if (long_pulse !== 0) begin errors++; $display("FAIL ferr_pulse_width got %0d long pulses want 0", long_pulse); end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = valid_cnt;
        bus.i_Baud = 8'd8;
        drive_bit(1'b0, 1);
        idle(30);
        checks++; if (busy_len !== 4) begin errors++; $display("FAIL glitch_b8_busy_len got %0d want 4", busy_len); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_b8_valid got %0d want 0", valid_cnt - v0); end
        checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL glitch_b8_busy_after got %b want 0", bus.o_Busy); end
        // Baud 0 behaves as 1 clock per bit: H=0, so busy lasts a single cycle
        bus.i_Baud = 8'd0;
        drive_bit(1'b0, 1);
        idle(20);
        checks++; if (busy_len !== 1) begin errors++; $display("FAIL glitch_b0_busy_len got %0d want 1", busy_len); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_b0_valid got %0d want 0", valid_cnt - v0); end
    endtask

    task automatic test_baud_latch();
        int v0;
        v0 = valid_cnt;
        bus.i_Baud = 8'd2;
        fork
            send_frame(8'h5A, 2, 1'b1, 1);
            begin
                repeat (3) @(negedge clk);
                bus.i_Baud = 8'd7;
            end
        join
        idle(10);
        checks++; if (bus.o_Data !== 8'h5A) begin errors++; $display("FAIL baud_latch_data got %h want %h", bus.o_Data, 8'h5A); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL baud_latch_valid got %0d want 1", valid_cnt - v0); end
        checks++; if (valid_cyc - busy_rise_cyc !== 1 + NBITS * 2) begin errors++; $display("FAIL baud_latch_latency got %0d want %0d", valid_cyc - busy_rise_cyc, 1 + NBITS * 2); end
    endtask

    task automatic test_enable();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        bus.i_Baud = 8'd4;
        fork
            send_frame(8'hF0, 4, 1'b1, 1);
            begin
                repeat (14) @(negedge clk);
                bus.i_Enable = 1'b0;
                @(negedge clk);
                checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL enable_busy_drop got %b want 0", bus.o_Busy); end
            end
        join
        idle(10);
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL enable_valid got %0d want 0", valid_cnt - v0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL enable_ferr got %0d want 0", ferr_cnt - f0); end
        bus.i_Enable = 1'b1;
        idle(4);
        send_frame(8'h96, 4, 1'b1, 1);
        idle(12);
        checks++; if (bus.o_Data !== 8'h96) begin errors++; $display("FAIL enable_recover_data got %h want %h", bus.o_Data, 8'h96); end
    endtask

    task automatic test_reset_mid();
        int v0;
        bus.i_Baud = 8'd4;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 4);
        drive_bit(1'b0, 4);
        drive_bit(1'b0, 4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.o_Data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want %h", bus.o_Data, 8'h00); end
        checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.o_Busy); end
        checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.o_Valid); end
        bus.i_Rx_Serial = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(8);
        checks++; if (bus.o_Data !== 8'h00) begin errors++; $display("FAIL rstmid_data_after got %h want %h", bus.o_Data, 8'h00); end
        v0 = valid_cnt;
        send_frame(8'h81, 4, 1'b1, 1);
        idle(12);
        checks++; if (bus.o_Data !== 8'h81) begin errors++; $display("FAIL rstmid_next_data got %h want %h", bus.o_Data, 8'h81); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rstmid_next_valid got %0d want 1", valid_cnt - v0); end
    endtask

`ifdef RXSHIFT_PARITY_EN
    task automatic test_parity();
        int v0, p0;
        logic [7:0] d;
        d = 8'h07;
        v0 = valid_cnt; p0 = perr_cnt;
        bus.i_Baud = 8'd4;
        drive_bit(1'b0, 4);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 4);
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 4);
        idle(12);
        checks++; if (bus.o_Data !== 8'h07) begin errors++; $display("FAIL parity_data got %h want %h", bus.o_Data, 8'h07); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL parity_valid got %0d want 1", valid_cnt - v0); end
        checks++; if (perr_at_valid !== 1'b1) begin errors++; $display("FAIL parity_err_with_valid got %b want 1", perr_at_valid); end
        checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL parity_err_count got %0d want 1", perr_cnt - p0); end
    endtask
`endif

    initial begin
        bus.i_Enable    = 1'b1;
        bus.i_Baud      = 8'd4;
        bus.i_Rx_Serial = 1'b1;
        rst             = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_clean();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_baud_latch();
        test_enable();
        test_reset_mid();
`ifdef RXSHIFT_PARITY_EN
        test_parity();
`endif
        checks++; if (long_pulse !== 0) begin errors++; $display("FAIL final_pulse_width got %0d long pulses want 0", long_pulse); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rxshift.md
Name: rxshift

Overview:
- Rx shift register; the downstream stage of the Tx shift register on the serial link.
- Watches the serial line and detects the start bit.
- Samples each bit at its centre, using the same programmable clocks-per-bit value as the transmitter.
- Assembles 8 data bits LSB first, checks the stop bit, and presents the byte with a one-cycle valid pulse to the register/APB side.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on i_Rx_Serial (legal values 2..3).

Ports:
- i_Pclk  input  1  system clock, rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Enable  input  1  receiver enable; low forces IDLE.
- i_Baud  input  8  clocks per bit; values 0 and 1 both mean 1.
- i_Rx_Serial  input  1  serial line; idles high.
- o_Data  output  8  last good received byte; held until the next good frame.
- o_Valid  output  1  one-cycle pulse when o_Data updates.
- o_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_Parity_Err  output  1  one-cycle parity error pulse (see Optional Feature).
- o_Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; o_Data = 0x00; o_Valid, o_Frame_Err, o_Parity_Err, o_Busy = 0.
  - Counters = 0; synchroniser flops = 1 (idle line).
  - Reset mid-frame discards the partial byte; o_Data keeps 0x00.
- Synchroniser:
  - i_Rx_Serial passes through SYNC_STAGES flops; all sampling uses the last stage (rx_s).
- Frame setup:
  - At start detection, B = max(i_Baud, 1) is latched into r_Baud and held for the whole frame; i_Baud changes mid-frame are ignored.
  - H = (B-1)>>1.
  - Clock counter is 8 bits; comparisons use 9-bit arithmetic, so there is no underflow at B=1.
- States:
  - IDLE: if i_Enable and rx_s==0 -> START, counter=0.
  - START:
    - While counter<H, increment.
    - At counter==H, sample rx_s.
    - Sample 0 -> DATA, counter=0, bit index=0.
    - Sample 1 (glitch/false start) -> IDLE, no output pulse.
  - DATA:
    - Counter runs 0..B-1; at B-1, shift rx_s into bit[index] and reset counter.
    - After index 7 -> STOP (or PARITY when enabled).
  - STOP:
    - Counter runs 0..B-1; at B-1, sample rx_s.
    - Sample 1: o_Data <= shift register, o_Valid=1 for that single cycle -> IDLE.
    - Sample 0: o_Frame_Err=1 for one cycle, o_Data unchanged -> BREAK.
  - BREAK: wait until rx_s==1, then -> IDLE. Prevents a held-low line being taken as a new start.
- Pulses: o_Valid, o_Frame_Err and o_Parity_Err are registered and each lasts exactly one clock.
- Timing with B>=2: the stop sample, and therefore o_Valid, occurs 1+H+9B clocks after the IDLE->START edge.
- Back-to-back frames: a start bit arriving the cycle after the STOP sample is detected. No dead time is required beyond the IDLE cycle.
- i_Enable low in any state: next edge -> IDLE, partial byte discarded, no pulses. An in-flight pulse already registered still completes its one cycle.

Optional Feature:
- Macro: RXSHIFT_PARITY_EN.
- Defined:
  - State PARITY sits between DATA and STOP and samples one even-parity bit at counter B-1.
  - Mismatch with ^data -> o_Parity_Err pulses one cycle at the STOP sample. o_Data still updates and o_Valid still pulses if the stop bit is good.
  - Latency becomes 1+H+10B.
- Undefined: no PARITY state; o_Parity_Err tied 0; frame is 10 bits.

Test Plan:
- Byte 0xA5, i_Baud=4, clean frame (start 0, LSB-first data, stop 1) -> o_Data=0xA5, o_Valid high exactly 1 cycle, o_Frame_Err=0, o_Busy low after.
- Loopback from the Tx shift register, i_Baud=8, bytes 0x00, 0xFF, 0x3C back-to-back -> three o_Valid pulses with matching o_Data, no errors.
- 1-clock low glitch on idle line, i_Baud=8 -> START aborts at the H sample, no o_Valid, returns to IDLE, o_Busy pulse of H+1 cycles.
- Frame 0x55 with stop bit forced 0 for 3 bit times, i_Baud=4 -> o_Frame_Err 1 cycle, o_Data keeps previous value, no new start detected until the line returns high.
- i_Reset asserted mid-DATA of 0x81 -> outputs 0 immediately. Next clean 0x81 frame -> o_Data=0x81.
- With RXSHIFT_PARITY_EN, 0x07 sent with parity bit 0 (wrong) -> o_Data=0x07, o_Valid=1, o_Parity_Err=1 in the same cycle.
